// File: rtl/addsub_seq_ctrl.sv
// Sequenced 4-bit add/subtract controller: shows A, then B, computes, then shows the result.
// Optional sticky overflow flag (clr_ovf / ovf_sticky) is enabled by defining ADDSUB_SEQ_STICKY_OVF_EN.
module addsub_seq_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ADDSUB_SEQ_STICKY_OVF_EN
    input  logic       clr_ovf,
    output logic       ovf_sticky,
`endif
    input  logic       start,
    input  logic       sub,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [3:0] disp_val,
    output logic [1:0] disp_sel,
    output logic [3:0] Result,
    output logic       C4,
    output logic       V
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW_A = 3'd1,
        SHOW_B = 3'd2,
        CALC   = 3'd3,
        SHOW_R = 3'd4
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     r_state;
    logic [7:0] r_dwell;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_sub;
    logic [3:0] r_result;
    logic       r_c4;
    logic       r_v;
    logic       r_done;

    logic [3:0] w_b_eff;
    logic [4:0] w_sum;
    logic       w_v;

    // Subtraction is A + ~B + 1, so the carry-out doubles as "no borrow".
    assign w_b_eff = r_b ^ {4{r_sub}};
    assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {4'b0000, r_sub};
    assign w_v     = (r_a[3] == w_b_eff[3]) && (w_sum[3] != r_a[3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_dwell  <= 8'd0;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_sub    <= 1'b0;
            r_result <= 4'd0;
            r_c4     <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= sub;
                        r_dwell <= DWELL_LAST;
                        r_state <= SHOW_A;
                    end
                end
                SHOW_A: begin
                    if (r_dwell == 8'd0) begin
                        r_dwell <= DWELL_LAST;
                        r_state <= SHOW_B;
                    end else begin
                        r_dwell <= r_dwell - 8'd1;
                    end
                end
                SHOW_B: begin
                    if (r_dwell == 8'd0) begin
                        r_dwell <= DWELL_LAST;
                        r_state <= CALC;
                    end else begin
                        r_dwell <= r_dwell - 8'd1;
                    end
                end
                CALC: begin
                    r_result <= w_sum[3:0];
                    r_c4     <= w_sum[4];
                    r_v      <= w_v;
                    r_dwell  <= DWELL_LAST;
                    r_state  <= SHOW_R;
                end
                SHOW_R: begin
                    if (r_dwell == 8'd0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_dwell <= r_dwell - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ADDSUB_SEQ_STICKY_OVF_EN
    logic r_ovf_sticky;

    // A new overflow takes precedence over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_state == CALC && w_v) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

    always_comb begin
        disp_val = r_result;
        disp_sel = 2'd2;
        case (r_state)
            SHOW_A: begin
                disp_val = r_a;
                disp_sel = 2'd0;
            end
            SHOW_B: begin
                disp_val = r_b;
                disp_sel = 2'd1;
            end
            default: begin
                disp_val = r_result;
                disp_sel = 2'd2;
            end
        endcase
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign Result = r_result;
    assign C4     = r_c4;
    assign V      = r_v;

endmodule

// File: doc/addsub_seq_ctrl.md
ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 SHALL have parameter: DWELL, 4, cycles each display phase is held (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request one add/sub sequence.
REQ-005 SHALL have port: sub  input  1  0 = A+B, 1 = A-B; captured with operands.
REQ-006 SHALL have port: A  input  4  two's-complement operand A.
REQ-007 SHALL have port: B  input  4  two's-complement operand B.
REQ-008 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port: done  output  1  one-cycle pulse on return to IDLE.
REQ-010 SHALL have port: disp_val  output  4  value for the downstream sign/magnitude 7-segment decoder.
REQ-011 SHALL have port: disp_sel  output  2  source of disp_val: 0 = A, 1 = B, 2 = result.
REQ-012 SHALL have port: Result  output  4  registered sum/difference.
REQ-013 SHALL have port: C4  output  1  registered carry-out (subtract: 1 = no borrow).
REQ-014 SHALL have port: V  output  1  registered signed-overflow flag.
REQ-015 SHALL have ports (only when the REQ-034 macro is defined): clr_ovf  input  1; ovf_sticky  output  1.

Function
REQ-016 SHALL implement states IDLE, SHOW_A, SHOW_B, CALC and SHOW_R.
REQ-017 SHALL, in IDLE with start=1, capture A, B and sub into operand registers and enter SHOW_A.
REQ-018 SHALL ignore start in every state except IDLE; an ignored start has no effect on state, operands or outputs.
REQ-019 SHALL ignore changes on A, B and sub after capture until the next accepted start.
REQ-020 SHALL hold SHOW_A, SHOW_B and SHOW_R for exactly DWELL cycles each, using a dwell counter reloaded on every state entry.
REQ-021 SHALL hold CALC for exactly 1 cycle, then enter SHOW_R.
REQ-022 SHALL, with start accepted at edge 0, hold SHOW_A in cycles 1..DWELL, SHOW_B in DWELL+1..2*DWELL, CALC in 2*DWELL+1, SHOW_R in 2*DWELL+2..3*DWELL+1, and IDLE with done=1 in cycle 3*DWELL+2.
REQ-023 SHALL compute on the edge leaving CALC: Result = A + (B XOR {4{sub}}) + sub, modulo 16; C4 = bit 4 of that 5-bit sum.
REQ-024 SHALL compute V = 1 when the captured A and the effective B (B XOR {4{sub}}) have equal MSBs and the Result MSB differs from them; otherwise V = 0.
REQ-025 SHALL hold Result, C4 and V stable outside the CALC update edge.
REQ-026 SHALL drive disp_val/disp_sel combinationally from state: captured A/0 in SHOW_A, captured B/1 in SHOW_B, Result/2 in CALC, SHOW_R and IDLE.
REQ-027 SHALL accept a start asserted in the done cycle (the done cycle is IDLE).
REQ-028 SHALL operate identically for DWELL=1, with no extra cycles in any phase.

Reset
REQ-029 SHALL give reset priority over start and over every state transition.
REQ-030 SHALL, while reset=1 is sampled, enter IDLE and clear the operands, Result, C4, V, done and the dwell counter to 0.
REQ-031 SHALL drive outputs after reset as: busy=0, done=0, disp_sel=2, disp_val=0, Result=0, C4=0, V=0, ovf_sticky=0.
REQ-032 SHALL, on reset mid-sequence, abandon the sequence without asserting done and without updating Result, C4 or V from the aborted operands.

Configuration
REQ-033 SHALL, with macro ADDSUB_SEQ_STICKY_OVF_EN undefined, omit the clr_ovf and ovf_sticky ports and their register.
REQ-034 SHALL, with macro ADDSUB_SEQ_STICKY_OVF_EN defined, set ovf_sticky on any CALC edge producing V=1 and keep it set until clr_ovf=1 or reset.
REQ-035 SHALL, when clr_ovf=1 coincides with a CALC edge producing V=1, leave ovf_sticky set (set wins over clear).

Verification
REQ-036 SHALL pass, with DWELL=2: start with A=3, B=4, sub=0 at edge 0 -> disp_sel 0,0,1,1,2,...; Result=7, C4=0, V=0 from cycle 6; done=1 in cycle 8 only.
REQ-037 SHALL pass: A=7, B=1, sub=0 -> Result=8, C4=0, V=1; then A=5, B=2, sub=1 -> Result=3, C4=1, V=0.
REQ-038 SHALL pass: A=2, B=5, sub=1 -> Result=0xD, C4=0, V=0; then A=8, B=1, sub=1 -> Result=7, C4=1, V=1.
REQ-039 SHALL pass: start pulses and A/B toggling during SHOW_B -> sequence length and Result unchanged; exactly one done pulse.
REQ-040 SHALL pass: reset asserted in SHOW_B -> next cycle IDLE, busy=0, Result=0, no done; a new start then completes normally.
REQ-041 SHALL pass, with ADDSUB_SEQ_STICKY_OVF_EN defined: an overflow op, then a non-overflow op -> ovf_sticky stays 1; clr_ovf pulse -> 0.
